// File: rtl/capture_write_arbiter.sv
// capture_write_arbiter
// Shares one capture-FIFO write port between the UART, SPI and I2C decoders.
// Each source owns a 1-entry holding slot. One pending slot is granted per cycle
// while the FIFO has room, and the written word carries a protocol tag:
// 00 = UART, 01 = SPI, 10 = I2C. Bytes that arrive while their slot is still
// occupied are dropped, and each source has its own saturating drop counter.
// Build option: define ARB_STRICT_PRIO_EN for fixed priority UART > SPI > I2C.
// With that option a busy UART can starve the other sources. By default the
// arbiter is round-robin and cannot starve any source.

module capture_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int DROP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            src_en,
    input  logic [2:0]            src_valid,
    input  logic [3*DATA_W-1:0]   src_data,
    input  logic                  fifo_full,
    input  logic                  clr_drop,
    output logic                  fifo_wr_en,
    output logic [DATA_W+1:0]     fifo_wr_data,
    output logic [2:0]            pending,
    output logic [DROP_W-1:0]     drop_uart,
    output logic [DROP_W-1:0]     drop_spi,
    output logic [DROP_W-1:0]     drop_i2c
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [2:0]        pend_q;
    logic [DATA_W-1:0] slot_q [3];
    logic [DROP_W-1:0] drop_q [3];
    logic [2:0]        eligible;
    logic [2:0]        gnt_oh;
    logic [2:0]        drop_evt;
    logic              gnt_vld;
    logic [1:0]        gnt_idx;
    logic [DATA_W-1:0] gnt_byte;

    // A disabled source is never granted, even if its slot is still marked pending.
    assign eligible = pend_q & src_en;

`ifndef ARB_STRICT_PRIO_EN
    logic [1:0] rr_ptr;

    function automatic logic [1:0] wrap3(input logic [1:0] base, input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        return 2'(s % 3);
    endfunction

    // Round-robin pick: search starts just after the last granted slot.
    // The loop runs backwards so that the nearest candidate is assigned last and wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        if (!fifo_full) begin
            for (int k = 2; k >= 0; k--) begin
                if (eligible[wrap3(rr_ptr, 32'(k) + 32'd1)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = wrap3(rr_ptr, 32'(k) + 32'd1);
                end
            end
        end
    end

    // Pointer moves only when a word is actually written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 2'd2;
        end else if (gnt_vld) begin
            rr_ptr <= gnt_idx;
        end
    end
`else
    // Fixed priority pick: the lowest index wins, so UART has the highest priority.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        if (!fifo_full) begin
            for (int k = 2; k >= 0; k--) begin
                if (eligible[k]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 2'(k);
                end
            end
        end
    end
`endif

    // Decode the grant to one-hot and select the granted byte.
    always_comb begin
        gnt_oh   = 3'b000;
        gnt_byte = '0;
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
        case (gnt_idx)
            2'd0:    gnt_byte = slot_q[0];
            2'd1:    gnt_byte = slot_q[1];
            2'd2:    gnt_byte = slot_q[2];
            default: gnt_byte = '0;
        endcase
    end

    // Gating with rst keeps the write port quiet for the whole reset pulse.
    assign fifo_wr_en   = gnt_vld & ~rst;
    assign fifo_wr_data = fifo_wr_en ? {gnt_idx, gnt_byte} : '0;
    assign pending      = pend_q;

    // A byte is lost when its slot is occupied and that slot is not draining this cycle.
    assign drop_evt = src_valid & src_en & pend_q & ~gnt_oh;

    // Slot capture, release and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!src_en[i]) begin
                    pend_q[i] <= 1'b0;
                    slot_q[i] <= '0;
                end else if (src_valid[i]) begin
                    if (!pend_q[i] || gnt_oh[i]) begin
                        slot_q[i] <= src_data[i*DATA_W +: DATA_W];
                        pend_q[i] <= 1'b1;
                    end
                end else if (gnt_oh[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating drop counters. A clear takes precedence over a drop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                drop_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clr_drop) begin
                    drop_q[i] <= '0;
                end else if (drop_evt[i] && drop_q[i] != DROP_MAX) begin
                    drop_q[i] <= drop_q[i] + 1'b1;
                end
            end
        end
    end

    assign drop_uart = drop_q[0];
    assign drop_spi  = drop_q[1];
    assign drop_i2c  = drop_q[2];

endmodule
